// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for modport_alu.
//   DEF_WIDTH / DEF_CWIDTH : default operand and command widths
//   arith_cmd_e / logic_cmd_e : command encodings for MODE=1 / MODE=0
//   flags_t   : registered flag bundle {cout, oflow, e, g, l, err}
//   op_req()  : whether a command exists, and which operands it needs
package alu_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_CWIDTH = 4;

  typedef enum logic [3:0] {
    A_ADD     = 4'd0,
    A_SUB     = 4'd1,
    A_ADD_CIN = 4'd2,
    A_SUB_CIN = 4'd3,
    A_INC_A   = 4'd4,
    A_DEC_A   = 4'd5,
    A_INC_B   = 4'd6,
    A_DEC_B   = 4'd7,
    A_CMP     = 4'd8,
    A_MUL_INC = 4'd9,
    A_MUL_SHL = 4'd10
  } arith_cmd_e;

  typedef enum logic [3:0] {
    L_AND     = 4'd0,
    L_NAND    = 4'd1,
    L_OR      = 4'd2,
    L_NOR     = 4'd3,
    L_XOR     = 4'd4,
    L_XNOR    = 4'd5,
    L_NOT_A   = 4'd6,
    L_NOT_B   = 4'd7,
    L_SHR1_A  = 4'd8,
    L_SHL1_A  = 4'd9,
    L_SHR1_B  = 4'd10,
    L_SHL1_B  = 4'd11,
    L_ROL_A_B = 4'd12,
    L_ROR_A_B = 4'd13
  } logic_cmd_e;

  // INP_VALID masks: bit0 = OPA, bit1 = OPB
  localparam logic [1:0] NEED_A  = 2'b01;
  localparam logic [1:0] NEED_B  = 2'b10;
  localparam logic [1:0] NEED_AB = 2'b11;

  typedef struct packed {
    logic       ok;    // command is defined for this mode
    logic [1:0] need;  // operands that must be flagged valid
  } op_req_t;

  typedef struct packed {
    logic cout;
    logic oflow;
    logic e;
    logic g;
    logic l;
    logic err;
  } flags_t;

  // cmd arrives zero-extended so any CWIDTH is judged the same way
  function automatic op_req_t op_req(input logic mode, input logic [31:0] cmd);
    op_req_t r;
    r.ok   = 1'b0;
    r.need = NEED_AB;
    if (mode) begin
      if (cmd <= 32'(A_MUL_SHL)) begin
        r.ok = 1'b1;
        case (cmd[3:0])
          A_INC_A, A_DEC_A: r.need = NEED_A;
          A_INC_B, A_DEC_B: r.need = NEED_B;
          default:          r.need = NEED_AB;
        endcase
      end
    end else begin
      if (cmd <= 32'(L_ROR_A_B)) begin
        r.ok = 1'b1;
        case (cmd[3:0])
          L_NOT_A, L_SHR1_A, L_SHL1_A: r.need = NEED_A;
          L_NOT_B, L_SHR1_B, L_SHL1_B: r.need = NEED_B;
          default:                     r.need = NEED_AB;
        endcase
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/modport_alu_mul.sv
// modport_alu_mul: two-stage registered multiplier.
//   clk  : clock, rising edge
//   clr  : synchronous clear of both stages (wins over en)
//   en   : advance the pipeline; hold everything when low
//   go   : x/y carry a multiply to start this cycle
//   x, y : pre-conditioned operands (W+1 bits each)
//   vld  : p holds a product that should drive the ALU outputs
//   p    : product truncated to W+2 bits
module modport_alu_mul
  import alu_pkg::*;
#(
  parameter int W = DEF_WIDTH
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         go,
  input  logic [W:0]   x,
  input  logic [W:0]   y,
  output logic         vld,
  output logic [W+1:0] p
);

  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe;
  logic [W+1:0]    s1_x, s1_y;
  logic [W+1:0]    prod;

  // operands are already W+2 wide, so the product wraps at the output width
  assign prod = s1_x * s1_y;

  always_ff @(posedge clk) begin
    if (clr) begin
      vld_pipe <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
      p        <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], go};
      s1_x     <= {1'b0, x};
      s1_y     <= {1'b0, y};
      p        <= prod;
    end
  end

  assign vld = vld_pipe[STAGES];

endmodule

// File: rtl/modport_alu.sv
// modport_alu: registered ALU behind alu_if.
//   CLK, RST        : clock and synchronous active-high reset
//   OPA, OPB        : operands (WIDTH)
//   CMD, MODE, CIN  : command, 1=arithmetic/0=logical, carry in
//   CE              : clock enable for all state
//   INP_VALID       : bit0 OPA valid, bit1 OPB valid
//   RES             : WIDTH+2 result
//   COUT, OFLOW, E, G, L, ERR : flags
// Single-cycle ops land in res_q/fl_q on their issue edge. Multiplies run
// through modport_alu_mul and take over the outputs for exactly one cycle
// when they complete; a single-cycle op issued that same cycle sits in
// res_q behind the product and shows next, unless a newer one replaces it.
module modport_alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CWIDTH = DEF_CWIDTH
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WIDTH-1:0]  OPA,
  input  logic [WIDTH-1:0]  OPB,
  input  logic [CWIDTH-1:0] CMD,
  input  logic              MODE,
  input  logic              CIN,
  input  logic              CE,
  input  logic [1:0]        INP_VALID,
  output logic [WIDTH+1:0]  RES,
  output logic              COUT,
  output logic              OFLOW,
  output logic              E,
  output logic              G,
  output logic              L,
  output logic              ERR
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  op_req_t          req;
  logic [3:0]       op;
  logic [WIDTH:0]   a_x, b_x, sum, diff;
  logic [WIDTH-1:0] lres;
  logic [SW-1:0]    amt;
  logic             rot_err;

  logic [WIDTH+1:0] nxt_res, res_q;
  flags_t           nxt_fl, fl_q;

  logic             mul_go, mul_vld;
  logic [WIDTH:0]   mul_x, mul_y;
  logic [WIDTH+1:0] mul_p;

  assign amt     = OPB[SW-1:0];
  assign rot_err = (OPB >> SW) != '0;

  always_comb begin
    req     = op_req(MODE, 32'(CMD));
    op      = 4'(CMD);
    a_x     = {1'b0, OPA};
    b_x     = {1'b0, OPB};
    sum     = '0;
    diff    = '0;
    lres    = '0;
    nxt_res = '0;
    nxt_fl  = '0;
    mul_go  = 1'b0;
    mul_x   = '0;
    mul_y   = '0;

    if (!req.ok || ((INP_VALID & req.need) != req.need)) begin
      nxt_fl.err = 1'b1;
    end else if (MODE) begin
      case (op)
        A_ADD, A_ADD_CIN, A_INC_A, A_INC_B: begin
          case (op)
            A_ADD:     sum = a_x + b_x;
            A_ADD_CIN: sum = a_x + b_x + {{WIDTH{1'b0}}, CIN};
            A_INC_A:   sum = a_x + 1'b1;
            default:   sum = b_x + 1'b1;
          endcase
          nxt_res     = {1'b0, sum};
          nxt_fl.cout = sum[WIDTH];
        end
        A_SUB, A_SUB_CIN, A_DEC_A, A_DEC_B: begin
          // one extra bit: its MSB is the borrow out of the WIDTH-bit subtract
          case (op)
            A_SUB:     diff = a_x - b_x;
            A_SUB_CIN: diff = a_x - b_x - {{WIDTH{1'b0}}, CIN};
            A_DEC_A:   diff = a_x - 1'b1;
            default:   diff = b_x - 1'b1;
          endcase
          nxt_res      = {2'b00, diff[WIDTH-1:0]};
          nxt_fl.oflow = diff[WIDTH];
        end
        A_CMP: begin
          nxt_fl.e = (OPA == OPB);
          nxt_fl.g = (OPA > OPB);
          nxt_fl.l = (OPA < OPB);
        end
        A_MUL_INC: begin
          mul_go = 1'b1;
          mul_x  = a_x + 1'b1;
          mul_y  = b_x + 1'b1;
        end
        A_MUL_SHL: begin
          mul_go = 1'b1;
          mul_x  = {OPA, 1'b0};
          mul_y  = b_x;
        end
        default: nxt_fl.err = 1'b1;
      endcase
    end else begin
      case (op)
        L_AND:     lres = OPA & OPB;
        L_NAND:    lres = ~(OPA & OPB);
        L_OR:      lres = OPA | OPB;
        L_NOR:     lres = ~(OPA | OPB);
        L_XOR:     lres = OPA ^ OPB;
        L_XNOR:    lres = ~(OPA ^ OPB);
        L_NOT_A:   lres = ~OPA;
        L_NOT_B:   lres = ~OPB;
        L_SHR1_A:  lres = OPA >> 1;
        L_SHL1_A:  lres = OPA << 1;
        L_SHR1_B:  lres = OPB >> 1;
        L_SHL1_B:  lres = OPB << 1;
        // a shift by WIDTH yields 0, so amt=0 needs no special case
        L_ROL_A_B: begin
          lres       = (OPA << amt) | (OPA >> (WIDTH - int'(amt)));
          nxt_fl.err = rot_err;
        end
        L_ROR_A_B: begin
          lres       = (OPA >> amt) | (OPA << (WIDTH - int'(amt)));
          nxt_fl.err = rot_err;
        end
        default:   nxt_fl.err = 1'b1;
      endcase
      nxt_res = {2'b00, lres};
    end
  end

  // a valid multiply leaves res_q alone so whatever is showing stays put
  always_ff @(posedge CLK) begin
    if (RST) begin
      res_q <= '0;
      fl_q  <= '0;
    end else if (CE && !mul_go) begin
      res_q <= nxt_res;
      fl_q  <= nxt_fl;
    end
  end

  modport_alu_mul #(.W(WIDTH)) u_mul (
    .clk (CLK),
    .clr (RST),
    .en  (CE),
    .go  (mul_go),
    .x   (mul_x),
    .y   (mul_y),
    .vld (mul_vld),
    .p   (mul_p)
  );

  assign RES = mul_vld ? mul_p : res_q;
  assign {COUT, OFLOW, E, G, L, ERR} = mul_vld ? 6'b000000 : fl_q;

endmodule

// File: tb/tb_modport_alu.sv
module tb_modport_alu;

  logic       clk = 1'b0;
  logic       RST, MODE, CIN, CE;
  logic [7:0] OPA, OPB;
  logic [3:0] CMD;
  logic [1:0] INP_VALID;
  logic [9:0] RES;
  logic       COUT, OFLOW, E, G, L, ERR;
  logic [5:0] fl;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic       m;
    logic [3:0] c;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [1:0] iv;
    logic [9:0] res;
    logic [5:0] fl;
  } vec_t;

  // flag vector order: {COUT, OFLOW, E, G, L, ERR}
  assign fl = {COUT, OFLOW, E, G, L, ERR};

  always #5 clk = ~clk;

  modport_alu #(.WIDTH(8), .CWIDTH(4)) dut (
    .CLK(clk), .RST(RST), .OPA(OPA), .OPB(OPB), .CMD(CMD), .MODE(MODE),
    .CIN(CIN), .CE(CE), .INP_VALID(INP_VALID), .RES(RES), .COUT(COUT),
    .OFLOW(OFLOW), .E(E), .G(G), .L(L), .ERR(ERR)
  );

  task automatic drive(input logic m, input logic [3:0] c, input logic [7:0] a,
                       input logic [7:0] b, input logic ci, input logic [1:0] iv);
    MODE = m; CMD = c; OPA = a; OPB = b; CIN = ci; INP_VALID = iv; CE = 1'b1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1; CE = 1'b0;
    drive(1'b1, 4'd0, 8'd0, 8'd0, 1'b0, 2'b00);
    CE = 1'b0;
    step(); step();
    n_chk++;
    if ({RES, fl} !== 16'h0000) begin
      n_fail++; $display("FAIL reset: got res=%h fl=%b exp res=000 fl=000000", RES, fl);
    end
    RST = 1'b0;
  endtask

  task automatic test_arith;
    vec_t v [12];
    v[0]  = '{1'b1, 4'd0,  8'd200, 8'd100, 1'b0, 2'b11, 10'h12C, 6'b100000};
    v[1]  = '{1'b1, 4'd1,  8'd5,   8'd10,  1'b0, 2'b11, 10'h0FB, 6'b010000};
    v[2]  = '{1'b1, 4'd2,  8'hFF,  8'h00,  1'b1, 2'b11, 10'h100, 6'b100000};
    v[3]  = '{1'b1, 4'd3,  8'd10,  8'd5,   1'b1, 2'b11, 10'h004, 6'b000000};
    v[4]  = '{1'b1, 4'd3,  8'd5,   8'd5,   1'b1, 2'b11, 10'h0FF, 6'b010000};
    v[5]  = '{1'b1, 4'd4,  8'h7F,  8'h00,  1'b0, 2'b01, 10'h080, 6'b000000};
    v[6]  = '{1'b1, 4'd5,  8'h00,  8'h00,  1'b0, 2'b01, 10'h0FF, 6'b010000};
    v[7]  = '{1'b1, 4'd6,  8'h00,  8'hFF,  1'b0, 2'b10, 10'h100, 6'b100000};
    v[8]  = '{1'b1, 4'd7,  8'h00,  8'h10,  1'b0, 2'b10, 10'h00F, 6'b000000};
    v[9]  = '{1'b1, 4'd8,  8'h33,  8'h33,  1'b0, 2'b11, 10'h000, 6'b001000};
    v[10] = '{1'b1, 4'd8,  8'h40,  8'h10,  1'b0, 2'b11, 10'h000, 6'b000100};
    v[11] = '{1'b1, 4'd8,  8'h01,  8'h02,  1'b0, 2'b11, 10'h000, 6'b000010};
    for (int i = 0; i < 12; i++) begin
      drive(v[i].m, v[i].c, v[i].a, v[i].b, v[i].ci, v[i].iv);
      step();
      n_chk++;
      if ({RES, fl} !== {v[i].res, v[i].fl}) begin
        n_fail++;
        $display("FAIL arith[%0d]: got res=%h fl=%b exp res=%h fl=%b", i, RES, fl, v[i].res, v[i].fl);
      end
    end
  endtask

  task automatic test_logic;
    vec_t v [16];
    v[0]  = '{1'b0, 4'd0,  8'hF0, 8'h3C, 1'b0, 2'b11, 10'h030, 6'b000000};
    v[1]  = '{1'b0, 4'd1,  8'hF0, 8'h3C, 1'b0, 2'b11, 10'h0CF, 6'b000000};
    v[2]  = '{1'b0, 4'd2,  8'hF0, 8'h0F, 1'b0, 2'b11, 10'h0FF, 6'b000000};
    v[3]  = '{1'b0, 4'd3,  8'hF0, 8'h0F, 1'b0, 2'b11, 10'h000, 6'b000000};
    v[4]  = '{1'b0, 4'd4,  8'hAA, 8'h0F, 1'b0, 2'b11, 10'h0A5, 6'b000000};
    v[5]  = '{1'b0, 4'd5,  8'hAA, 8'h0F, 1'b0, 2'b11, 10'h05A, 6'b000000};
    v[6]  = '{1'b0, 4'd6,  8'h0F, 8'h00, 1'b0, 2'b01, 10'h0F0, 6'b000000};
    v[7]  = '{1'b0, 4'd7,  8'h00, 8'h55, 1'b0, 2'b10, 10'h0AA, 6'b000000};
    v[8]  = '{1'b0, 4'd8,  8'h81, 8'h00, 1'b0, 2'b01, 10'h040, 6'b000000};
    v[9]  = '{1'b0, 4'd9,  8'h81, 8'h00, 1'b0, 2'b01, 10'h002, 6'b000000};
    v[10] = '{1'b0, 4'd10, 8'h00, 8'h02, 1'b0, 2'b10, 10'h001, 6'b000000};
    v[11] = '{1'b0, 4'd11, 8'h00, 8'hC0, 1'b0, 2'b10, 10'h080, 6'b000000};
    v[12] = '{1'b0, 4'd12, 8'h81, 8'h01, 1'b0, 2'b11, 10'h003, 6'b000000};
    v[13] = '{1'b0, 4'd12, 8'h81, 8'h11, 1'b0, 2'b11, 10'h003, 6'b000001};
    v[14] = '{1'b0, 4'd13, 8'h01, 8'h03, 1'b0, 2'b11, 10'h020, 6'b000000};
    v[15] = '{1'b0, 4'd13, 8'h81, 8'h00, 1'b0, 2'b11, 10'h081, 6'b000000};
    for (int i = 0; i < 16; i++) begin
      drive(v[i].m, v[i].c, v[i].a, v[i].b, v[i].ci, v[i].iv);
      step();
      n_chk++;
      if ({RES, fl} !== {v[i].res, v[i].fl}) begin
        n_fail++;
        $display("FAIL logic[%0d]: got res=%h fl=%b exp res=%h fl=%b", i, RES, fl, v[i].res, v[i].fl);
      end
    end
  endtask

  task automatic test_errors;
    vec_t v [9];
    v[0] = '{1'b1, 4'd0,  8'd1,  8'd1,  1'b0, 2'b01, 10'h000, 6'b000001};
    v[1] = '{1'b1, 4'd1,  8'd9,  8'd1,  1'b0, 2'b00, 10'h000, 6'b000001};
    v[2] = '{1'b0, 4'd14, 8'hFF, 8'h01, 1'b0, 2'b11, 10'h000, 6'b000001};
    v[3] = '{1'b0, 4'd15, 8'hFF, 8'h01, 1'b0, 2'b11, 10'h000, 6'b000001};
    v[4] = '{1'b1, 4'd11, 8'hFF, 8'h01, 1'b0, 2'b11, 10'h000, 6'b000001};
    v[5] = '{1'b1, 4'd4,  8'h10, 8'h01, 1'b0, 2'b10, 10'h000, 6'b000001};
    v[6] = '{1'b0, 4'd7,  8'h10, 8'h01, 1'b0, 2'b01, 10'h000, 6'b000001};
    v[7] = '{1'b1, 4'd9,  8'd3,  8'd4,  1'b0, 2'b10, 10'h000, 6'b000001};
    // the rejected multiply must not surface one cycle later either
    v[8] = '{1'b1, 4'd8,  8'h01, 8'h01, 1'b0, 2'b11, 10'h000, 6'b001000};
    for (int i = 0; i < 9; i++) begin
      drive(v[i].m, v[i].c, v[i].a, v[i].b, v[i].ci, v[i].iv);
      step();
      n_chk++;
      if ({RES, fl} !== {v[i].res, v[i].fl}) begin
        n_fail++;
        $display("FAIL errors[%0d]: got res=%h fl=%b exp res=%h fl=%b", i, RES, fl, v[i].res, v[i].fl);
      end
    end
  endtask

  task automatic test_hold;
    drive(1'b1, 4'd0, 8'd200, 8'd100, 1'b0, 2'b11);
    step();
    drive(1'b1, 4'd1, 8'd5, 8'd10, 1'b0, 2'b11);
    CE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if ({RES, fl} !== {10'h12C, 6'b100000}) begin
        n_fail++; $display("FAIL hold[%0d]: got res=%h fl=%b exp res=12c fl=100000", i, RES, fl);
      end
    end
    // a multiply stalled by CE=0 must neither complete nor be lost
    drive(1'b1, 4'd9, 8'd3, 8'd4, 1'b0, 2'b11);
    step();
    CE = 1'b0;
    step(); step();
    n_chk++;
    if ({RES, fl} !== {10'h12C, 6'b100000}) begin
      n_fail++; $display("FAIL hold_mul_stall: got res=%h fl=%b exp res=12c fl=100000", RES, fl);
    end
    drive(1'b1, 4'd8, 8'd7, 8'd7, 1'b0, 2'b11);
    step();
    n_chk++;
    if ({RES, fl} !== {10'd20, 6'b000000}) begin
      n_fail++; $display("FAIL hold_mul_resume: got res=%h fl=%b exp res=014 fl=000000", RES, fl);
    end
  endtask

  task automatic test_multiply;
    drive(1'b1, 4'd0, 8'd1, 8'd1, 1'b0, 2'b11);
    step();
    drive(1'b1, 4'd9, 8'd3, 8'd4, 1'b0, 2'b11);
    step();
    n_chk++;
    if ({RES, fl} !== {10'd2, 6'b000000}) begin
      n_fail++; $display("FAIL mul_latency: got res=%h fl=%b exp res=002 fl=000000", RES, fl);
    end
    drive(1'b1, 4'd0, 8'd1, 8'd2, 1'b0, 2'b11);
    step();
    n_chk++;
    if ({RES, fl} !== {10'd20, 6'b000000}) begin
      n_fail++; $display("FAIL mul_inc: got res=%h fl=%b exp res=014 fl=000000", RES, fl);
    end
    drive(1'b1, 4'd10, 8'd3, 8'd5, 1'b0, 2'b11);
    step();
    n_chk++;
    if ({RES, fl} !== {10'd3, 6'b000000}) begin
      n_fail++; $display("FAIL mul_then_add: got res=%h fl=%b exp res=003 fl=000000", RES, fl);
    end
    drive(1'b1, 4'd8, 8'd5, 8'd5, 1'b0, 2'b11);
    step();
    n_chk++;
    if ({RES, fl} !== {10'd30, 6'b000000}) begin
      n_fail++; $display("FAIL mul_shl: got res=%h fl=%b exp res=01e fl=000000", RES, fl);
    end
    drive(1'b1, 4'd9, 8'd200, 8'd5, 1'b0, 2'b11);
    step();
    n_chk++;
    if ({RES, fl} !== {10'd0, 6'b001000}) begin
      n_fail++; $display("FAIL mul_deferred_cmp: got res=%h fl=%b exp res=000 fl=001000", RES, fl);
    end
    drive(1'b0, 4'd0, 8'hFF, 8'h0F, 1'b0, 2'b11);
    step();
    // 201*6 = 1206, truncated to 10 bits = 182
    n_chk++;
    if ({RES, fl} !== {10'd182, 6'b000000}) begin
      n_fail++; $display("FAIL mul_trunc: got res=%h fl=%b exp res=0b6 fl=000000", RES, fl);
    end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 4'd9, 8'd3, 8'd4, 1'b0, 2'b11);
    step();
    drive(1'b1, 4'd0, 8'd1, 8'd1, 1'b0, 2'b11);
    step();
    n_chk++;
    if ({RES, fl} !== {10'd20, 6'b000000}) begin
      n_fail++; $display("FAIL b2b_mul: got res=%h fl=%b exp res=014 fl=000000", RES, fl);
    end
    drive(1'b0, 4'd0, 8'hFF, 8'h0F, 1'b0, 2'b11);
    step();
    n_chk++;
    if ({RES, fl} !== {10'h00F, 6'b000000}) begin
      n_fail++; $display("FAIL b2b_newer_wins: got res=%h fl=%b exp res=00f fl=000000", RES, fl);
    end
    drive(1'b1, 4'd9, 8'd100, 8'd9, 1'b0, 2'b11);
    step();
    drive(1'b1, 4'd10, 8'd3, 8'd5, 1'b0, 2'b11);
    step();
    n_chk++;
    if ({RES, fl} !== {10'h3F2, 6'b000000}) begin
      n_fail++; $display("FAIL b2b_mul1: got res=%h fl=%b exp res=3f2 fl=000000", RES, fl);
    end
    drive(1'b0, 4'd0, 8'hFF, 8'h3C, 1'b0, 2'b11);
    step();
    n_chk++;
    if ({RES, fl} !== {10'd30, 6'b000000}) begin
      n_fail++; $display("FAIL b2b_mul2: got res=%h fl=%b exp res=01e fl=000000", RES, fl);
    end
    step();
    n_chk++;
    if ({RES, fl} !== {10'h03C, 6'b000000}) begin
      n_fail++; $display("FAIL b2b_tail: got res=%h fl=%b exp res=03c fl=000000", RES, fl);
    end
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 4'd0, 8'd1, 8'd1, 1'b0, 2'b11);
    step();
    drive(1'b1, 4'd9, 8'd3, 8'd4, 1'b0, 2'b11);
    step();
    drive(1'b1, 4'd0, 8'd1, 8'd1, 1'b0, 2'b11);
    RST = 1'b1;
    step();
    n_chk++;
    if ({RES, fl} !== 16'h0000) begin
      n_fail++; $display("FAIL rst_mid: got res=%h fl=%b exp res=000 fl=000000", RES, fl);
    end
    RST = 1'b0; CE = 1'b0;
    step();
    n_chk++;
    if ({RES, fl} !== 16'h0000) begin
      n_fail++; $display("FAIL rst_hold: got res=%h fl=%b exp res=000 fl=000000", RES, fl);
    end
    drive(1'b1, 4'd9, 8'd0, 8'd0, 1'b0, 2'b11);
    step();
    n_chk++;
    if ({RES, fl} !== 16'h0000) begin
      n_fail++; $display("FAIL rst_no_stale: got res=%h fl=%b exp res=000 fl=000000", RES, fl);
    end
    drive(1'b0, 4'd0, 8'hFF, 8'hFF, 1'b0, 2'b11);
    CE = 1'b0;
    step();
    n_chk++;
    if ({RES, fl} !== 16'h0000) begin
      n_fail++; $display("FAIL rst_stall: got res=%h fl=%b exp res=000 fl=000000", RES, fl);
    end
    CE = 1'b1;
    step();
    n_chk++;
    if ({RES, fl} !== {10'd1, 6'b000000}) begin
      n_fail++; $display("FAIL rst_fresh_mul: got res=%h fl=%b exp res=001 fl=000000", RES, fl);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_errors();
    test_hold();
    test_multiply();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
